// File: rtl/uart_pkg.sv
// uart_pkg: frame state encoding and parity-type constants shared by the UART TX and RX paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_baud_cnt.sv
// uart_tx_baud_cnt: per-bit edge counter; bit_done pulses on the last of prescale cycles (0 means 64).
module uart_tx_baud_cnt (
    input  logic       CLK,
    input  logic       RST,
    input  logic       en,
    input  logic [5:0] prescale,
    output logic       bit_done
);

    logic [5:0] cnt_q;

    // 6-bit wraparound makes prescale=0 compare against 63, i.e. 64 cycles per bit
    assign bit_done = en && (cnt_q == prescale - 6'd1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            cnt_q <= 6'd0;
        else
            cnt_q <= (!en || bit_done) ? 6'd0 : cnt_q + 6'd1;
    end

endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter framing start, LSB-first data, optional parity and stop bits.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [5:0]            prescale,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    uart_state_e           state_q;
    logic [CW-1:0]         bit_cnt_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_nx;
    logic                  par_q;
    logic                  par_en_q;
    logic [5:0]            pre_q;
    logic                  bit_done;

    // data is shifted out so the next bit is always at index 0
    assign data_nx = data_q >> 1;

    uart_tx_baud_cnt u_baud (
        .CLK      (CLK),
        .RST      (RST),
        .en       (state_q != IDLE),
        .prescale (pre_q),
        .bit_done (bit_done)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            TX_OUT    <= 1'b1;
            busy      <= 1'b0;
            bit_cnt_q <= '0;
            data_q    <= '0;
            par_q     <= 1'b0;
            par_en_q  <= 1'b0;
            pre_q     <= 6'd0;
        end else begin
            case (state_q)
                IDLE: if (DATA_VALID) begin
                    state_q  <= START;
                    TX_OUT   <= 1'b0;
                    busy     <= 1'b1;
                    data_q   <= P_DATA;
                    par_q    <= (PAR_TYP == PAR_EVEN) ? ^P_DATA : ~^P_DATA;
                    par_en_q <= PAR_EN;
                    pre_q    <= prescale;
                end
                START: if (bit_done) begin
                    state_q   <= DATA;
                    TX_OUT    <= data_q[0];
                    bit_cnt_q <= '0;
                end
                DATA: if (bit_done) begin
                    if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
                        state_q <= par_en_q ? PARITY : STOP;
                        TX_OUT  <= par_en_q ? par_q : 1'b1;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        data_q    <= data_nx;
                        TX_OUT    <= data_nx[0];
                    end
                end
                PARITY: if (bit_done) begin
                    state_q <= STOP;
                    TX_OUT  <= 1'b1;
                end
                STOP: if (bit_done) begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    TX_OUT  <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
